volume_gain_apply: RTL

VOLUME_GAIN_APPLY -- requirements
Module: volume_gain_apply

---
 rtl/volume_gain_apply.sv | 94 +++++++++
 1 files changed

// File: rtl/volume_gain_apply.sv
// volume_gain_apply: ramps a thermometer-coded volume level one step per sample and
// scales each sample by level/8 using a 4-cycle shift-and-add multiplier.
module volume_gain_apply #(
    parameter int W = 16
) (
    input  logic         Clk,
    input  logic         RST,
    input  logic [7:0]   vol_therm,
    input  logic [W-1:0] in_sample,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_sample,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   cur_level,
    output logic         therm_err
);
    typedef enum logic [1:0] {IDLE, MUL, FIN, HOLD} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cur_level_q, cur_level_d, target_q, target_d, lvl_q, lvl_d;
    logic [W-1:0]        smp_q, smp_d, out_q, out_d;
    logic signed [W+3:0] acc_q, acc_d, ext, shr;
    logic [1:0]          idx_q, idx_d;
    logic                therm_err_q, therm_err_d, legal;

    always_comb begin
        // a legal code is a contiguous run of ones from bit 0, so v & (v+1) clears it
        legal       = (vol_therm & (vol_therm + 8'd1)) == 8'd0;
        target_d    = legal ? 4'($countones(vol_therm)) : target_q;
        therm_err_d = !legal;
        ext         = $signed(smp_q);
        shr         = acc_q >>> 3;
        state_d     = state_q;
        cur_level_d = cur_level_q;
        lvl_d       = lvl_q;
        smp_d       = smp_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        out_d       = out_q;
        case (state_q)
            IDLE: if (in_valid) begin
                smp_d       = in_sample;
                lvl_d       = cur_level_q;
                acc_d       = '0;
                idx_d       = '0;
                state_d     = MUL;
                cur_level_d = cur_level_q < target_q ? cur_level_q + 4'd1 :
                              cur_level_q > target_q ? cur_level_q - 4'd1 : cur_level_q;
            end
            MUL: begin
                acc_d   = lvl_q[idx_q] ? acc_q + (ext <<< idx_q) : acc_q;
                idx_d   = idx_q + 2'd1;
                state_d = idx_q == 2'd3 ? FIN : MUL;
            end
            FIN: begin
                out_d   = shr[W-1:0];
                state_d = HOLD;
            end
            HOLD: state_d = out_ready ? IDLE : HOLD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (RST) begin
            state_q     <= IDLE;
            cur_level_q <= '0;
            target_q    <= '0;
            lvl_q       <= '0;
            smp_q       <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            out_q       <= '0;
            therm_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_level_q <= cur_level_d;
            target_q    <= target_d;
            lvl_q       <= lvl_d;
            smp_q       <= smp_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            out_q       <= out_d;
            therm_err_q <= therm_err_d;
        end
    end

    assign in_ready   = state_q == IDLE;
    assign out_valid  = state_q == HOLD;
    assign out_sample = out_q;
    assign cur_level  = cur_level_q;
    assign therm_err  = therm_err_q;
endmodule
